// File: rtl/lmsm_pkg.sv
// Shared constants and types for the load-multiple / store-multiple sequencer.
package lmsm_pkg;

   localparam int unsigned NREGS = 8;
   localparam int unsigned AW    = 16;
   localparam int unsigned IW    = $clog2(NREGS);

   localparam logic OP_LM = 1'b0;
   localparam logic OP_SM = 1'b1;

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit finder: index of the least significant 1 in vec.
module lsb_prio_enc #(
   parameter int unsigned N = 8,
   parameter int unsigned W = 3
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (vec[i] && !valid) begin
            idx   = W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lmsm_sequencer.sv
// LM/SM controller: walks the register mask LSB first, one memory access per
// set bit at consecutive addresses, and drives the active-low write strobes.
module lmsm_sequencer #(
   parameter int unsigned NREGS = lmsm_pkg::NREGS,
   parameter int unsigned AW    = lmsm_pkg::AW,
   parameter int unsigned IW    = lmsm_pkg::IW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_store,
   input  logic [NREGS-1:0] reg_list,
   input  logic [AW-1:0]    base_addr,
   input  logic             mem_ready,
   output logic             busy,
   output logic             done,
   output logic [IW-1:0]    reg_idx,
   output logic [AW-1:0]    mem_addr,
   output logic             mem_rd,
   output logic             mem_wr_n,
   output logic             rf_wr_n,
   output logic [3:0]       xfer_count
);
   import lmsm_pkg::*;

   state_t           state;
   logic [NREGS-1:0] mask;
   logic [NREGS-1:0] mask_rest;
   logic             op;
   logic [IW-1:0]    enc_idx;
   logic             enc_valid;
   logic             in_access;

   lsb_prio_enc #(.N(NREGS), .W(IW)) u_enc (
      .vec   (mask),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // Write strobes are combinational so they fall only in the completing cycle
   // and rise the instant reset is asserted.
   always_comb begin
      in_access = (state == ACCESS) && enc_valid;
      mask_rest = mask & (mask - NREGS'(1));
      reg_idx   = enc_idx;
      mem_wr_n  = !(in_access && (op == OP_SM) && mem_ready);
      rf_wr_n   = !(in_access && (op == OP_LM) && mem_ready);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         mask       <= '0;
         op         <= OP_LM;
         mem_addr   <= '0;
         xfer_count <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_rd     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  xfer_count <= '0;
                  if (reg_list != '0) begin
                     mask     <= reg_list;
                     op       <= is_store;
                     mem_addr <= base_addr;
                     busy     <= 1'b1;
                     mem_rd   <= (is_store == OP_LM);
                     state    <= ACCESS;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  mask       <= mask_rest;
                  mem_addr   <= mem_addr + AW'(1);
                  xfer_count <= xfer_count + 4'd1;
                  if (mask_rest == '0) begin
                     busy   <= 1'b0;
                     mem_rd <= 1'b0;
                     done   <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Scoreboard bench for lmsm_sequencer: stimulus queues expected accesses/done,
// a negedge monitor pops and compares whenever a strobe or done is seen.
module tb_lmsm_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        is_store;
   logic [7:0]  reg_list;
   logic [15:0] base_addr;
   logic        mem_ready;
   logic        busy;
   logic        done;
   logic [2:0]  reg_idx;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr_n;
   logic        rf_wr_n;
   logic [3:0]  xfer_count;

   typedef struct {
      bit is_done;
      bit store;
      int idx;
      int addr;
      int cnt;
      int cyc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   c0 = 0;
   bit   busy_seen = 1'b0;

   lmsm_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_store   (is_store),
      .reg_list   (reg_list),
      .base_addr  (base_addr),
      .mem_ready  (mem_ready),
      .busy       (busy),
      .done       (done),
      .reg_idx    (reg_idx),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_wr_n   (mem_wr_n),
      .rf_wr_n    (rf_wr_n),
      .xfer_count (xfer_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic push_acc(input bit st, input int idx, input int addr, input int at);
      exp_t e;
      e.is_done = 1'b0; e.store = st; e.idx = idx; e.addr = addr; e.cnt = 0; e.cyc = at;
      sb.push_back(e);
   endtask

   task automatic push_done(input int cnt, input int at);
      exp_t e;
      e.is_done = 1'b1; e.store = 1'b0; e.idx = 0; e.addr = 0; e.cnt = cnt; e.cyc = at;
      sb.push_back(e);
   endtask

   task automatic begin_op(input logic st, input logic [7:0] lst, input logic [15:0] b);
      @(posedge clk); #1;
      c0        = cyc;
      start     = 1'b1;
      is_store  = st;
      reg_list  = lst;
      base_addr = b;
   endtask

   task automatic end_start();
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < lim);
      if (!done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (busy) busy_seen = 1'b1;
         if (!mem_wr_n || !rf_wr_n || done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: wr_n=%b rf_wr_n=%b done=%b idx=%0d addr=0x%0h required no event (cycle %0d)",
                        mem_wr_n, rf_wr_n, done, reg_idx, mem_addr, cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("event_cycle", cyc, mon_e.cyc);
               if (mon_e.is_done) begin
                  chk("done_flag", {31'd0, done}, 32'd1);
                  chk("done_busy", {31'd0, busy}, 32'd0);
                  chk("done_count", {28'd0, xfer_count}, mon_e.cnt);
                  chk("done_strobes", {29'd0, mem_rd, mem_wr_n, rf_wr_n}, 32'b011);
               end else begin
                  chk("acc_idx", {29'd0, reg_idx}, mon_e.idx);
                  chk("acc_addr", {16'd0, mem_addr}, mon_e.addr);
                  chk("acc_busy", {31'd0, busy}, 32'd1);
                  chk("acc_done", {31'd0, done}, 32'd0);
                  if (mon_e.store) chk("sm_strobes", {29'd0, mem_rd, mem_wr_n, rf_wr_n}, 32'b001);
                  else             chk("lm_strobes", {29'd0, mem_rd, mem_wr_n, rf_wr_n}, 32'b110);
               end
            end
         end
      end
   end

   logic [15:0] sm_addr [8];

   initial begin
      sm_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001,
                  16'h0002, 16'h0003, 16'h0004, 16'h0005};
      reset     = 1'b0;
      start     = 1'b0;
      is_store  = 1'b0;
      reg_list  = '0;
      base_addr = '0;
      mem_ready = 1'b1;

      #12;
      chk("rst_busy",  {31'd0, busy},     32'd0);
      chk("rst_done",  {31'd0, done},     32'd0);
      chk("rst_rd",    {31'd0, mem_rd},   32'd0);
      chk("rst_wr_n",  {31'd0, mem_wr_n}, 32'd1);
      chk("rst_rf_n",  {31'd0, rf_wr_n},  32'd1);
      chk("rst_idx",   {29'd0, reg_idx},  32'd0);
      chk("rst_addr",  {16'd0, mem_addr}, 32'd0);
      chk("rst_count", {28'd0, xfer_count}, 32'd0);
      #11 reset = 1'b1;

      // LM 1010_0101 from 0x0040
      begin_op(1'b0, 8'b1010_0101, 16'h0040);
      push_acc(1'b0, 0, 16'h0040, c0 + 1);
      push_acc(1'b0, 2, 16'h0041, c0 + 2);
      push_acc(1'b0, 5, 16'h0042, c0 + 3);
      push_acc(1'b0, 7, 16'h0043, c0 + 4);
      push_done(4, c0 + 5);
      end_start();
      wait_done(30);

      // empty list: done next cycle, count cleared, never busy
      busy_seen = 1'b0;
      begin_op(1'b0, 8'h00, 16'h5555);
      push_done(0, c0 + 1);
      end_start();
      wait_done(30);
      chk("empty_busy_never", {31'd0, busy_seen}, 32'd0);

      // SM all registers from 0xFFFE, address wraps
      begin_op(1'b1, 8'hFF, 16'hFFFE);
      for (int i = 0; i < 8; i++) push_acc(1'b1, i, sm_addr[i], c0 + 1 + i);
      push_done(8, c0 + 9);
      end_start();
      wait_done(30);

      // LM 0000_0110 with a two-cycle stall on the second access
      begin_op(1'b0, 8'b0000_0110, 16'h0100);
      push_acc(1'b0, 1, 16'h0100, c0 + 1);
      push_acc(1'b0, 2, 16'h0101, c0 + 4);
      push_done(2, c0 + 5);
      end_start();
      @(posedge clk); #1;
      mem_ready = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("stall_idx",  {29'd0, reg_idx},  32'd2);
         chk("stall_addr", {16'd0, mem_addr}, 32'h0101);
         chk("stall_rf_n", {31'd0, rf_wr_n},  32'd1);
         chk("stall_rd",   {31'd0, mem_rd},   32'd1);
         chk("stall_busy", {31'd0, busy},     32'd1);
      end
      @(posedge clk); #1;
      mem_ready = 1'b1;
      wait_done(30);

      // start pulsed while busy and during DONE must be ignored
      begin_op(1'b0, 8'h0F, 16'h0200);
      for (int i = 0; i < 4; i++) push_acc(1'b0, i, 16'h0200 + i, c0 + 1 + i);
      push_done(4, c0 + 5);
      end_start();
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b1; reg_list = 8'hF0; base_addr = 16'h9999;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(30);
      start = 1'b1; reg_list = 8'h3C;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("ignored_count", {28'd0, xfer_count}, 32'd4);
      chk("ignored_addr",  {16'd0, mem_addr},   32'h0204);
      chk("ignored_busy",  {31'd0, busy},       32'd0);

      // reset in the middle of an SM after two transfers
      begin_op(1'b1, 8'hFF, 16'h1000);
      push_acc(1'b1, 0, 16'h1000, c0 + 1);
      push_acc(1'b1, 1, 16'h1001, c0 + 2);
      end_start();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_wr_n", {31'd0, mem_wr_n}, 32'd0);
      #1 reset = 1'b0;
      #1;
      chk("mid_rst_wr_n",  {31'd0, mem_wr_n},   32'd1);
      chk("mid_rst_rf_n",  {31'd0, rf_wr_n},    32'd1);
      chk("mid_rst_busy",  {31'd0, busy},       32'd0);
      chk("mid_rst_rd",    {31'd0, mem_rd},     32'd0);
      chk("mid_rst_idx",   {29'd0, reg_idx},    32'd0);
      chk("mid_rst_addr",  {16'd0, mem_addr},   32'd0);
      chk("mid_rst_count", {28'd0, xfer_count}, 32'd0);
      chk("mid_rst_sb",    sb.size(),           32'd0);
      @(posedge clk); #3;
      reset = 1'b1;

      // fresh LM after reset
      begin_op(1'b0, 8'h81, 16'h0030);
      push_acc(1'b0, 0, 16'h0030, c0 + 1);
      push_acc(1'b0, 7, 16'h0031, c0 + 2);
      push_done(2, c0 + 3);
      end_start();
      wait_done(30);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lmsm_sequencer.md
Name: lmsm_sequencer

Overview:
- Multi-cycle controller for the load-multiple (LM) and store-multiple (SM) instructions.
- Walks an 8-bit register list from LSB to MSB and issues one memory access per set bit, at consecutive addresses starting at the base address.
- Drives the active-low write strobes that the 16-bit datapath registers and the register file expect.
- Sits between the main control FSM (which pulses start and waits for done) and the register file / memory.

Parameters:
- NREGS, 8, number of architectural registers; width of reg_list.
- AW, 16, address and data-path width.
- IW, 3, register index width, equal to clog2(NREGS).

Ports:
- clk  in  1  system clock; all state updates on posedge so strobes are stable at the datapath's negedge capture.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the main FSM; sampled only in IDLE.
- is_store  in  1  0 = LM (memory to RF), 1 = SM (RF to memory); latched at start.
- reg_list  in  NREGS  register mask; latched at start.
- base_addr  in  AW  first memory address; latched at start.
- mem_ready  in  1  memory completes the current access this cycle.
- busy  out  1  high from the cycle after an accepted start until done is asserted.
- done  out  1  one-cycle completion pulse.
- reg_idx  out  IW  register index of the current access.
- mem_addr  out  AW  address of the current access.
- mem_rd  out  1  active-high read strobe (LM).
- mem_wr_n  out  1  active-low memory write strobe (SM).
- rf_wr_n  out  1  active-low register-file write strobe (LM).
- xfer_count  out  4  number of completed transfers for the current or last operation.

Behaviour:
- States: IDLE, ACCESS, DONE.
- Reset (async, reset=0):
  - State goes to IDLE; busy=0, done=0, mem_rd=0.
  - mem_wr_n=1, rf_wr_n=1.
  - reg_idx=0, mem_addr=0, xfer_count=0; internal mask cleared.
  - Reset mid-operation aborts immediately; no further strobes are issued.
- IDLE:
  - start=1 and reg_list!=0: latch mask, is_store and addr=base_addr; clear xfer_count; go to ACCESS.
  - start=1 and reg_list==0: go to DONE with no accesses.
- ACCESS:
  - reg_idx = index of the lowest set bit of the remaining mask (combinational).
  - mem_addr = the registered address.
  - LM: mem_rd=1.
  - SM: mem_wr_n = ~mem_ready, i.e. low only in the completing cycle.
  - LM: rf_wr_n = ~mem_ready, combinational, low only in the completing cycle.
  - On posedge with mem_ready=1: clear that mask bit, addr = addr+1 (mod 2^AW, so FFFF wraps to 0000), xfer_count+1.
  - If the cleared mask becomes zero, go to DONE.
  - On posedge with mem_ready=0: hold everything (stall). Strobes stay inactive except mem_rd.
- DONE:
  - done=1 for exactly one cycle; busy=0; all strobes inactive.
  - Then IDLE.
  - xfer_count and mem_addr hold their final values until the next accepted start.
- Latency with mem_ready tied high (accepted start in cycle 0):
  - N set bits give ACCESS in cycles 1..N and done in cycle N+1.
  - An empty list gives done in cycle 1.
- start while busy or in DONE is ignored, not queued.
- Strobes are never active outside ACCESS; at most one access completes per cycle.

Decomposition:
- Shared package lmsm_pkg:
  - state enum (IDLE, ACCESS, DONE).
  - NREGS, AW, IW constants.
  - op encoding (OP_LM=0, OP_SM=1).
- One sub-module: lsb_prio_enc. Combinational lowest-set-bit finder, NREGS in; IW index plus valid out.

Test Plan:
- LM, reg_list=8'b1010_0101, base 0x0040, mem_ready=1:
  - reg_idx 0,2,5,7 with mem_addr 0x0040..0x0043 in cycles 1–4.
  - rf_wr_n low in cycles 1–4; mem_wr_n high throughout.
  - done in cycle 5; xfer_count=4.
- SM, reg_list=8'hFF, base 0xFFFE:
  - mem_addr sequence FFFE, FFFF, 0000..0005.
  - mem_wr_n low in 8 cycles; rf_wr_n never low.
  - done in cycle 9; xfer_count=8.
- reg_list=0 with start:
  - done in cycle 1, busy never high.
  - No strobe activity; xfer_count=0.
- LM, reg_list=8'b0000_0110, mem_ready low for 2 cycles during the 2nd access:
  - reg_idx=2 and mem_addr=base+1 held for 3 cycles.
  - rf_wr_n high during the stall, low only in the completing cycle.
  - done one cycle after that completing cycle.
- start pulsed while busy:
  - Ignored: mask, address and xfer_count are unaffected.
- reset asserted mid-SM (after 2 transfers):
  - All outputs reach reset values asynchronously; mem_wr_n=1 immediately.
  - After release, a new LM start runs normally from its own base_addr.
